// File: rtl/piano_pkg.sv
// Shared constants for the piano voice: note pitches, mode/octave codes, FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package piano_pkg;

  // Scale-degree frequencies in Hz for C D E F G A B of the base octave.
  localparam int F_C = 262;
  localparam int F_D = 294;
  localparam int F_E = 330;
  localparam int F_F = 349;
  localparam int F_G = 392;
  localparam int F_A = 440;
  localparam int F_B = 494;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_LIVE    = 2'd1;
  localparam logic [1:0] MODE_SUSTAIN = 2'd2;

  localparam logic [1:0] OCT_BASE = 2'd0;
  localparam logic [1:0] OCT_UP   = 2'd1;
  localparam logic [1:0] OCT_DOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_SUSTAIN = 2'd2
  } state_t;

  function automatic int note_freq(input int degree);
    case (degree)
      0:       return F_C;
      1:       return F_D;
      2:       return F_E;
      3:       return F_F;
      4:       return F_G;
      5:       return F_A;
      default: return F_B;
    endcase
  endfunction

  // Half-period in clock cycles for a key index and an octave code.
  // Each group of 7 keys sits one octave higher, i.e. half the period.
  function automatic int half_period(input int clk_hz, input int key, input logic [1:0] oct);
    int hp;
    hp = (clk_hz / (2 * note_freq(key % 7))) >> (key / 7);
    case (oct)
      OCT_UP:   hp = hp >> 1;
      OCT_DOWN: hp = hp << 1;
      default:  hp = hp;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser + debounce: clk, rst, raw (async switch) in; db (debounced level) out.
// Latency: a stable change on raw reaches db after DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none; free-running per-key filter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle: accept it.
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piano_voice.sv
// Single-voice tone engine: debounced keys -> lowest pressed key -> square wave on speaker.
// Ports: clk, rst, keys, mode, oct_sel in; speaker, note_valid, note_idx, led out.
// Latency: key press to note_valid is DEBOUNCE_CYCLES+3 cycles. Backpressure: none.
module piano_voice
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = 7,
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SUSTAIN_CYCLES  = 25_000_000,
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          mode,
  input  logic [1:0]          oct_sel,
  output logic                speaker,
  output logic                note_valid,
  output logic [IW-1:0]       note_idx,
  output logic [NUM_KEYS-1:0] led
);

  // Key 0 shifted down an octave has the longest half-period of all keys.
  localparam int TW  = $clog2(half_period(CLK_HZ, 0, OCT_DOWN) + 1);
  localparam int SCW = $clog2(SUSTAIN_CYCLES + 1);

  logic [NUM_KEYS-1:0] db;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  state_t              state;
  state_t              state_n;
  logic [IW-1:0]       note;
  logic [IW-1:0]       note_n;
  logic [1:0]          oct_q;
  logic [1:0]          oct_n;
  logic [TW-1:0]       tcnt;
  logic [SCW-1:0]      scnt;
  int                  hp_n;
  logic                tone_restart;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (keys[g]),
      .db  (db[g])
    );
  end

  // Lowest-index pressed key; scanning downwards lets the lowest hit win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  assign oct_n = (oct_sel == OCT_UP || oct_sel == OCT_DOWN) ? oct_sel : OCT_BASE;

  // The FSM consumes the combinational pick and registers it as the sounding
  // note in the same edge, so selection and state change land together.
  always_comb begin
    state_n = state;
    note_n  = note;
    if (mode != MODE_LIVE && mode != MODE_SUSTAIN) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (pick_valid) state_n = ST_PLAY;
        ST_PLAY:    if (!pick_valid) state_n = (mode == MODE_SUSTAIN) ? ST_SUSTAIN : ST_IDLE;
        ST_SUSTAIN: begin
          if (pick_valid)        state_n = ST_PLAY;
          else if (scnt == '0)   state_n = ST_IDLE;
        end
        default:    state_n = ST_IDLE;
      endcase
    end
    // SUSTAIN keeps the last note; only PLAY follows the live selection.
    if (state_n == ST_PLAY) note_n = pick_idx;
  end

  always_comb begin
    hp_n         = half_period(CLK_HZ, int'(note_n), oct_n);
    tone_restart = (state_n == ST_PLAY && state != ST_PLAY) ||
                   (state_n != ST_IDLE && (note_n != note || oct_n != oct_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      note    <= '0;
      oct_q   <= OCT_BASE;
      scnt    <= '0;
      tcnt    <= '0;
      speaker <= 1'b0;
    end else begin
      state <= state_n;
      note  <= note_n;
      oct_q <= oct_n;

      if (state_n == ST_SUSTAIN && state != ST_SUSTAIN) scnt <= SCW'(SUSTAIN_CYCLES - 1);
      else if (state_n == ST_SUSTAIN)                   scnt <= scnt - 1'b1;
      else                                              scnt <= '0;

      if (state_n == ST_IDLE || tone_restart) begin
        tcnt    <= '0;
        speaker <= 1'b0;
      end else if (tcnt == TW'(hp_n - 1)) begin
        tcnt    <= '0;
        speaker <= ~speaker;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_comb begin
    note_valid = (state != ST_IDLE);
    note_idx   = note_valid ? note : '0;
    led        = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      led[i] = note_valid && (note == IW'(i));
    end
  end

endmodule
